uart_baud_ctrl: RTL
===================

Name: uart_baud_ctrl

Overview:
Synthesizable baud-rate controller and tick scheduler for the UART.
- Holds the active baud selection and generates the oversample tick and bit tick from the single system clock.
- Reconfigures the rate through a req/ack handshake, and only while the UART link is idle, so no frame is ever split across two rates.
- Sits between the UART configuration register and the TX/RX engines; the engines consume its ticks and report busy.

Parameters:
OVERSAMPLE, 16, oversample ticks per bit; range 2..64.
DIV_SEL0, 651, clocks per oversample tick at 4800 baud; minimum 2; DIV_* fit 16 bits.
DIV_SEL1, 326, clocks per oversample tick at 9600 baud.
DIV_SEL2, 163, clocks per oversample tick at 19200 baud.
DIV_SEL3, 81, clocks per oversample tick at 38400 baud.
RESET_SEL, 2'b01, selection loaded at reset.

Ports:
clk_in  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  tick enable.
cfg_req  input  1  rate-change request (level).
cfg_sel  input  2  requested rate {s1,s0}: 00=4800, 01=9600, 10=19200, 11=38400.
cfg_ack  output  1  one-cycle pulse when the new rate is applied.
link_busy  input  1  OR of TX busy and RX busy.
pending  output  1  request accepted, waiting for the link to go idle.
cur_sel  output  2  active rate selection.
tick_os  output  1  oversample tick, one-cycle pulse.
tick_bit  output  1  bit tick, one-cycle pulse.

Behaviour:
- Reset (async assert, sync release): state RUN; div_cnt=0, os_cnt=0; cur_sel=RESET_SEL; cfg_ack=0, pending=0, tick_os=0, tick_bit=0. All outputs are registered.
- DIV is DIV_SEL[cur_sel]. div_cnt is 16 bits; os_cnt is clog2(OVERSAMPLE) bits.
- Tick counters, en=1:
  - div_cnt counts 0..DIV-1, then wraps to 0.
  - tick_os=1 for the cycle following the edge on which div_cnt wraps. The period is exactly DIV cycles, and the first tick_os after a counter clear comes DIV cycles after the clear.
  - os_cnt increments on each wrap of div_cnt and itself wraps at OVERSAMPLE-1.
  - tick_bit coincides with the tick_os on which os_cnt wraps, i.e. one tick_bit per OVERSAMPLE tick_os.
- en=0: div_cnt and os_cnt are held at 0 and both ticks are 0. The handshake still operates.
- FSM states:
  - RUN: if cfg_req=1, latch cfg_sel into sel_q, set pending=1, go to WAIT_IDLE.
  - WAIT_IDLE:
    - Ticks continue at the old rate.
    - If cfg_req=0, abandon: pending=0, no ack, go to RUN.
    - Else if link_busy=0, go to APPLY.
    - cfg_sel changes while in WAIT_IDLE are ignored (sel_q was captured at acceptance).
  - APPLY (exactly one cycle): cur_sel<=sel_q; div_cnt<=0; os_cnt<=0; cfg_ack=1; pending<=0; ticks are forced to 0 in this cycle even if a wrap was due. Next state is RUN.
- Latency: cfg_req rises at edge N with link idle → WAIT_IDLE at N+1 → cfg_ack high in the cycle after edge N+2, with cur_sel updated in that same cycle.
- Requester protocol: drop cfg_req in the cycle after cfg_ack. If cfg_req is still high in RUN, it is treated as a new request (same sel reapplied, counters cleared again).
- link_busy is sampled only in WAIT_IDLE. If link_busy stays high, the request waits indefinitely with pending=1.
- A request to the rate already active still goes through APPLY: counters clear and ack is issued.
- Reset mid-operation discards any pending request; no ack is issued.

Test Plan:
All scenarios use overrides OVERSAMPLE=4, DIV_SEL0=16, DIV_SEL1=8, DIV_SEL2=4, DIV_SEL3=2.
1. Reset then en=1, no requests → cur_sel=01; tick_os every 8 cycles, first 8 cycles after reset release; tick_bit every 32 cycles, coincident with every 4th tick_os.
2. cfg_req=1, cfg_sel=11, link_busy=0 → pending=1 next cycle; cfg_ack one-cycle pulse 2 cycles after req; cur_sel=11; tick_os period becomes 2; no tick in the APPLY cycle.
3. link_busy=1 while cfg_req=1, cfg_sel=00 for 50 cycles → pending=1 throughout; ticks keep period 8; link_busy falls → cfg_ack after 1 cycle; period becomes 16.
4. In WAIT_IDLE, change cfg_sel 00→10 then drop link_busy → cur_sel=00 (latched value). Separately, drop cfg_req before link_busy clears → pending=0, no cfg_ack, cur_sel unchanged.
5. en=0 for 20 cycles mid-count → tick_os and tick_bit stay 0; on en=1, first tick_os comes exactly DIV cycles later.
6. Assert rst_n=0 while pending=1 with sel=11 → immediately pending=0, cur_sel=01, ticks 0; after release, no cfg_ack and tick_os period is 8.

Source files
------------

// File: rtl/uart_baud_ctrl.sv
`timescale 1ns/1ps
// uart_baud_ctrl: baud-rate selection register and tick scheduler for the UART.
// Derives the oversample tick and the bit tick from the system clock, and swaps
// the active rate through a req/ack handshake only while the link is idle so
// that no frame ever straddles two rates.
//
// Ports:
//   clk_in    - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   en        - tick enable; counters are held at zero while low
//   cfg_req   - rate-change request (level, dropped by requester after ack)
//   cfg_sel   - requested rate: 00=4800, 01=9600, 10=19200, 11=38400
//   cfg_ack   - one-cycle pulse in the cycle the new rate becomes active
//   link_busy - OR of TX and RX busy
//   pending   - request accepted, waiting for the link to go idle
//   cur_sel   - active rate selection
//   tick_os   - oversample tick, one-cycle pulse
//   tick_bit  - bit tick, coincident with every OVERSAMPLE-th tick_os
module uart_baud_ctrl #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_SEL0   = 651,
  parameter int unsigned DIV_SEL1   = 326,
  parameter int unsigned DIV_SEL2   = 163,
  parameter int unsigned DIV_SEL3   = 81,
  parameter logic [1:0]  RESET_SEL  = 2'b01
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cfg_req,
  input  logic [1:0] cfg_sel,
  output logic       cfg_ack,
  input  logic       link_busy,
  output logic       pending,
  output logic [1:0] cur_sel,
  output logic       tick_os,
  output logic       tick_bit
);

  localparam int unsigned DIV_W = 16;
  localparam int unsigned OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_IDLE = 2'd1,
    APPLY     = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         cur_sel_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]    os_cnt_q, os_cnt_d;
  logic               pending_d, cfg_ack_d, tick_os_d, tick_bit_d;
  logic [DIV_W-1:0]   div_last;
  logic               wrap;
  logic               os_wrap;

  // Terminal count of the divider for the active rate.
  always_comb begin
    div_last = DIV_W'(DIV_SEL1 - 1);
    case (cur_sel)
      2'd0:    div_last = DIV_W'(DIV_SEL0 - 1);
      2'd1:    div_last = DIV_W'(DIV_SEL1 - 1);
      2'd2:    div_last = DIV_W'(DIV_SEL2 - 1);
      default: div_last = DIV_W'(DIV_SEL3 - 1);
    endcase
  end

  assign wrap    = en && (div_cnt_q == div_last);
  assign os_wrap = (os_cnt_q == OS_LAST);

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cur_sel_d  = cur_sel;
    pending_d  = pending;
    cfg_ack_d  = 1'b0;
    div_cnt_d  = '0;
    os_cnt_d   = '0;
    tick_os_d  = 1'b0;
    tick_bit_d = 1'b0;

    if (en) begin
      div_cnt_d  = wrap ? '0 : div_cnt_q + DIV_W'(1);
      os_cnt_d   = wrap ? (os_wrap ? '0 : os_cnt_q + OS_W'(1)) : os_cnt_q;
      tick_os_d  = wrap;
      tick_bit_d = wrap && os_wrap;
    end

    case (state_q)
      RUN: begin
        if (cfg_req) begin
          sel_d     = cfg_sel;
          pending_d = 1'b1;
          state_d   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!cfg_req) begin
          pending_d = 1'b0;
          state_d   = RUN;
        end else if (!link_busy) begin
          // Registers loaded here are visible during the APPLY cycle:
          // new rate, cleared counters, ack high, ticks suppressed.
          state_d    = APPLY;
          cur_sel_d  = sel_q;
          pending_d  = 1'b0;
          cfg_ack_d  = 1'b1;
          div_cnt_d  = '0;
          os_cnt_d   = '0;
          tick_os_d  = 1'b0;
          tick_bit_d = 1'b0;
        end
      end
      APPLY:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      sel_q     <= RESET_SEL;
      cur_sel   <= RESET_SEL;
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
      pending   <= 1'b0;
      cfg_ack   <= 1'b0;
      tick_os   <= 1'b0;
      tick_bit  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cur_sel   <= cur_sel_d;
      div_cnt_q <= div_cnt_d;
      os_cnt_q  <= os_cnt_d;
      pending   <= pending_d;
      cfg_ack   <= cfg_ack_d;
      tick_os   <= tick_os_d;
      tick_bit  <= tick_bit_d;
    end
  end

endmodule
